// File: rtl/mem_pkg.sv
// Shared types and constants for the memory access controller.
// Holds the RAM geometry (512 x 32), the wait-counter width and the
// controller state encoding used by mem_access_ctrl and mem_wait_counter.
package mem_pkg;

   localparam int unsigned ADDR_W = 9;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 4;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] word_t;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      CAPTURE,
      RESP
   } state_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that times the extra RAM access cycles.
// Ports:
//   clock, reset_n : clock and synchronous active-low reset
//   load, load_val : load the counter with the number of wait cycles
//   done_c         : high in the last wait cycle (count == 1)
module mem_wait_counter
   import mem_pkg::*;
(
   input  logic             clock,
   input  logic             reset_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done_c
);

   logic [CNT_W-1:0] count;

   // Count down to zero and stop there.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - CNT_W'(1);
      end
   end

   assign done_c = (count == CNT_W'(1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller between the CPU control unit and a 512x32 RAM.
// Latches one request into MAR/MDR, pulses the RAM strobe for one cycle,
// captures read data into MDR and returns it over a valid/ready response.
// Optional feature: define MEM_CTRL_WAITSTATE_EN to insert WAIT_CYCLES
// access cycles between the strobe and the capture/response.
// Ports:
//   clock, reset_n          : clock, synchronous active-low reset
//   req_valid/req_ready     : request handshake (write flag, address, data)
//   rsp_valid/rsp_ready     : response handshake (write echo, MDR data)
//   ram_read/ram_write      : one-cycle RAM strobes
//   ram_address/ram_datain  : driven from MAR/MDR
//   ram_dataout             : RAM read data
//   busy                    : controller not in IDLE
module mem_access_ctrl
   import mem_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_write,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              ram_read,
   output logic              ram_write,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_datain,
   input  logic [DATA_W-1:0] ram_dataout,
   output logic              busy
);

   if (WAIT_CYCLES > 15) begin : g_wait_range
      $error("WAIT_CYCLES must be in 0..15");
   end

   state_t state, state_n;
   addr_t  mar, mar_n;
   word_t  mdr, mdr_n;
   logic   flag, flag_n;
   logic   req_ready_n, ram_read_n, ram_write_n;
   logic   rsp_valid_n, rsp_write_n, busy_n;
   logic   access_done;

`ifdef MEM_CTRL_WAITSTATE_EN
   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

   logic wait_load;
   logic wait_done_c;

   mem_wait_counter u_wait (
      .clock    (clock),
      .reset_n  (reset_n),
      .load     (wait_load),
      .load_val (WAIT_LOAD),
      .done_c   (wait_done_c)
   );
`endif

   // Next state and next registered outputs.
   always_comb begin
      state_n     = state;
      mar_n       = mar;
      mdr_n       = mdr;
      flag_n      = flag;
      req_ready_n = 1'b0;
      ram_read_n  = 1'b0;
      ram_write_n = 1'b0;
      rsp_valid_n = 1'b0;
      rsp_write_n = 1'b0;
      access_done = 1'b0;
`ifdef MEM_CTRL_WAITSTATE_EN
      wait_load   = 1'b0;
`endif

      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               mar_n       = req_addr;
               flag_n      = req_write;
               if (req_write) begin
                  mdr_n = req_wdata;
               end
               // Strobe is registered so it is high exactly during ISSUE.
               ram_write_n = req_write;
               ram_read_n  = !req_write;
               state_n     = ISSUE;
            end else begin
               req_ready_n = 1'b1;
            end
         end
         ISSUE: begin
`ifdef MEM_CTRL_WAITSTATE_EN
            if (WAIT_CYCLES != 0) begin
               wait_load = 1'b1;
               state_n   = WAIT;
            end else begin
               access_done = 1'b1;
            end
`else
            access_done = 1'b1;
`endif
         end
`ifdef MEM_CTRL_WAITSTATE_EN
         WAIT: begin
            access_done = wait_done_c;
         end
`endif
         CAPTURE: begin
            mdr_n       = ram_dataout;
            rsp_valid_n = 1'b1;
            state_n     = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               req_ready_n = 1'b1;
               state_n     = IDLE;
            end else begin
               rsp_valid_n = 1'b1;
               rsp_write_n = flag;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      // Access phase over: writes respond directly, reads capture first.
      if (access_done) begin
         if (flag) begin
            rsp_valid_n = 1'b1;
            rsp_write_n = 1'b1;
            state_n     = RESP;
         end else begin
            state_n = CAPTURE;
         end
      end

      busy_n = (state_n != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state     <= IDLE;
         mar       <= '0;
         mdr       <= '0;
         flag      <= 1'b0;
         req_ready <= 1'b0;
         ram_read  <= 1'b0;
         ram_write <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_write <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         mar       <= mar_n;
         mdr       <= mdr_n;
         flag      <= flag_n;
         req_ready <= req_ready_n;
         ram_read  <= ram_read_n;
         ram_write <= ram_write_n;
         rsp_valid <= rsp_valid_n;
         rsp_write <= rsp_write_n;
         busy      <= busy_n;
      end
   end

   assign ram_address = mar;
   assign ram_datain  = mdr;
   assign rsp_rdata   = mdr;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus random
// traffic, a behavioural RAM, and a scoreboard monitor on the strobes and
// the response channel.
module tb_mem_access_ctrl;

   localparam int TB_WAIT = 2;
`ifdef MEM_CTRL_WAITSTATE_EN
   localparam int EXTRA = TB_WAIT;
`else
   localparam int EXTRA = 0;
`endif

   logic        clock = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [8:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_write;
   logic [31:0] rsp_rdata;
   logic        ram_read;
   logic        ram_write;
   logic [8:0]  ram_address;
   logic [31:0] ram_datain;
   logic [31:0] ram_dataout;
   logic        busy;

   mem_access_ctrl #(.WAIT_CYCLES(TB_WAIT)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_write   (rsp_write),
      .rsp_rdata   (rsp_rdata),
      .ram_read    (ram_read),
      .ram_write   (ram_write),
      .ram_address (ram_address),
      .ram_datain  (ram_datain),
      .ram_dataout (ram_dataout),
      .busy        (busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        w;
      logic [8:0]  a;
      logic [31:0] d;
      int          acc;
   } strobe_exp_t;

   typedef struct {
      logic        w;
      logic [31:0] d;
      int          acc;
   } rsp_exp_t;

   strobe_exp_t sq[$];
   rsp_exp_t    rq[$];
   bit [31:0]   ram     [512];
   bit [31:0]   ref_mem [512];

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   bp_mode = 0;
   bit   prev_strobe = 0;
   bit   in_rsp = 0;
   bit   expect_idle = 0;
   logic        held_w;
   logic [31:0] held_d;

   function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h at cycle %0d", name, got, exp, cyc);
      end
   endfunction

   function automatic void flag_fail(string name);
      checks++;
      errors++;
      $display("FAIL %s at cycle %0d", name, cyc);
   endfunction

   always @(posedge clock) cyc <= cyc + 1;

   // Synchronous 512x32 RAM: data appears the cycle after the read strobe.
   always @(posedge clock) begin
      if (ram_write) ram[ram_address] <= ram_datain;
      if (ram_read)  ram_dataout <= ram[ram_address];
   end

   // Response consumer: 0 = always ready, 1 = random, 2 = stalled.
   initial begin
      rsp_ready = 1'b1;
      forever begin
         @(posedge clock);
         #2;
         case (bp_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'($urandom_range(0, 1));
            default: rsp_ready = 1'b0;
         endcase
      end
   end

   // Monitor: strobes and responses against the scoreboard queues.
   always @(negedge clock) begin
      strobe_exp_t s;
      rsp_exp_t    r;
      chk("strobe_excl", 64'(ram_read & ram_write), 64'(0));
      if (expect_idle) begin
         chk("idle_after_hs", 64'({req_ready, rsp_valid, busy}), 64'(3'b100));
         expect_idle = 0;
      end
      if (ram_read || ram_write) begin
         chk("strobe_width", 64'(prev_strobe), 64'(0));
         if (sq.size() == 0) begin
            flag_fail("unexpected_strobe");
         end else begin
            s = sq.pop_front();
            chk("strobe_kind", 64'({ram_write, ram_read}), 64'(s.w ? 2'b10 : 2'b01));
            chk("strobe_addr", 64'(ram_address), 64'(s.a));
            if (s.w) chk("strobe_data", 64'(ram_datain), 64'(s.d));
            chk("strobe_cycle", 64'(cyc), 64'(s.acc));
            chk("busy_issue", 64'(busy), 64'(1));
         end
      end
      prev_strobe = ram_read || ram_write;
      if (rsp_valid) begin
         if (rq.size() == 0) begin
            flag_fail("unexpected_rsp");
         end else begin
            r = rq[0];
            if (!in_rsp) begin
               chk("rsp_latency", 64'(cyc - r.acc + 1), 64'(r.w ? 2 + EXTRA : 3 + EXTRA));
               chk("rsp_write", 64'(rsp_write), 64'(r.w));
               chk("rsp_rdata", 64'(rsp_rdata), 64'(r.d));
               held_w = rsp_write;
               held_d = rsp_rdata;
               in_rsp = 1;
            end else begin
               chk("rsp_stable", 64'({rsp_write, rsp_rdata}), 64'({held_w, held_d}));
               chk("req_ready_stall", 64'(req_ready), 64'(0));
            end
            if (rsp_ready) begin
               void'(rq.pop_front());
               in_rsp = 0;
               expect_idle = 1;
            end
         end
      end
   end

   // Offer a request, record its expectations just before the accept edge.
   task automatic do_req(input logic w, input logic [8:0] a, input logic [31:0] d);
      int n;
      n = 0;
      @(negedge clock);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      while (!req_ready && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (!req_ready) begin
         flag_fail("req_accept_timeout");
         req_valid = 1'b0;
         return;
      end
      sq.push_back('{w: w, a: a, d: d, acc: cyc + 1});
      rq.push_back('{w: w, d: (w ? d : ref_mem[a]), acc: cyc + 1});
      if (w) ref_mem[a] = d;
      @(posedge clock);
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clock);
      while (!(rq.size() == 0 && sq.size() == 0 && req_ready) && n < 500) begin
         @(negedge clock);
         n++;
      end
      if (n >= 500) flag_fail("idle_timeout");
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      int n;
      reset_n   = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;

      // Reset values.
      repeat (3) @(negedge clock);
      chk("rst_ctrl", 64'({req_ready, rsp_valid, rsp_write, ram_read, ram_write, busy}), 64'(0));
      chk("rst_addr", 64'(ram_address), 64'(0));
      chk("rst_datain", 64'(ram_datain), 64'(0));
      chk("rst_rdata", 64'(rsp_rdata), 64'(0));
      reset_n = 1'b1;
      @(negedge clock);
      chk("ready_after_rst", 64'(req_ready), 64'(1));

      // Directed write then read-back of 0x005.
      do_req(1'b1, 9'h005, 32'hDEADBEEF);
      wait_idle();
      do_req(1'b0, 9'h005, 32'h0);
      wait_idle();

      // Response backpressure on a read of 0x1FF, with an ignored request.
      bp_mode = 2;
      do_req(1'b0, 9'h1FF, 32'h0);
      n = 0;
      while (!rsp_valid && n < 50) begin
         @(negedge clock);
         n++;
      end
      chk("bp_rsp_seen", 64'(rsp_valid), 64'(1));
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 9'h1FF;
      req_wdata = 32'hBAD0BAD0;
      repeat (5) @(negedge clock);
      req_valid = 1'b0;
      chk("bp_still_valid", 64'(rsp_valid), 64'(1));
      bp_mode = 0;
      wait_idle();

      // Reset during ISSUE of a write to 0x000.
      do_req(1'b1, 9'h000, 32'hCAFE0000);
      @(negedge clock);
      chk("mid_issue_strobe", 64'(ram_write), 64'(1));
      reset_n = 1'b0;
      @(negedge clock);
      rq.delete();
      sq.delete();
      chk("mid_rst_ctrl", 64'({req_ready, rsp_valid, rsp_write, ram_read, ram_write, busy}), 64'(0));
      chk("mid_rst_addr", 64'(ram_address), 64'(0));
      chk("mid_rst_rdata", 64'(rsp_rdata), 64'(0));
      reset_n = 1'b1;
      @(negedge clock);
      chk("mid_rst_ready", 64'(req_ready), 64'(1));

      // Re-request and back-to-back traffic.
      do_req(1'b1, 9'h000, 32'h12345678);
      do_req(1'b1, 9'h1FF, 32'h00000001);
      do_req(1'b0, 9'h000, 32'h0);
      do_req(1'b0, 9'h1FF, 32'h0);
      wait_idle();

      // Random traffic with random response backpressure.
      bp_mode = 1;
      for (int i = 0; i < 40; i++) begin
         logic [8:0] a;
         case ($urandom_range(0, 3))
            0:       a = 9'h000;
            1:       a = 9'h1FF;
            default: a = 9'($urandom_range(0, 511));
         endcase
         do_req(1'($urandom_range(0, 1)), a, $urandom);
      end
      bp_mode = 0;
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Memory access controller between the CPU control unit/datapath and the 512x32 RAM. It latches a request into internal MAR/MDR registers and sequences the RAM Read/Write strobes for exactly one cycle. It captures read data into the MDR and returns a response over a valid/ready handshake. One transaction is in flight at a time.

Parameters:
ADDR_W, 9, RAM word-address width (512 words)
DATA_W, 32, data word width
WAIT_CYCLES, 2, extra access cycles inserted when MEM_CTRL_WAITSTATE_EN is defined (ignored otherwise; legal range 0-15)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  transaction complete
rsp_ready  in  1  consumer accepts response
rsp_write  out  1  echo of req_write for this response
rsp_rdata  out  DATA_W  MDR contents (read data)
ram_read  out  1  to RAM Read
ram_write  out  1  to RAM Write
ram_address  out  ADDR_W  to RAM address (driven from MAR)
ram_datain  out  DATA_W  to RAM DataIn (driven from MDR)
ram_dataout  in  DATA_W  from RAM DataOut
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset_n=0 at a clock edge): state=IDLE. MAR=0, MDR=0, ram_read=0, ram_write=0, rsp_valid=0, rsp_write=0, busy=0. req_ready becomes 1 in the cycle after reset deasserts. Reset mid-transaction aborts it with no response and no RAM strobe on the next cycle.
- States: IDLE, ISSUE, WAIT, CAPTURE, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch MAR<=req_addr, write flag<=req_write, and MDR<=req_wdata (writes only), then go to ISSUE. Otherwise stay in IDLE.
- ISSUE (1 cycle): ram_address=MAR.
  - Write: ram_write=1 and ram_datain=MDR, then go to RESP (or WAIT).
  - Read: ram_read=1, then go to CAPTURE (or WAIT).
- WAIT: present only with the macro. Strobes are deasserted and a 4-bit counter counts WAIT_CYCLES. When the counter expires, go to CAPTURE (read) or RESP (write). If WAIT_CYCLES=0, WAIT is skipped.
- CAPTURE (read only, 1 cycle): MDR<=ram_dataout, then go to RESP.
- RESP: rsp_valid=1, rsp_rdata=MDR, rsp_write=flag. Hold until rsp_ready=1, then go to IDLE on that edge. rsp_valid, rsp_rdata and rsp_write must stay stable while stalled.
- Strobes are registered outputs and are never asserted outside ISSUE. ram_read and ram_write are never high together.
- Latency without the macro, counted from the acceptance edge with rsp_ready held high:
  - read: rsp_valid asserted 3 cycles after acceptance
  - write: rsp_valid asserted 2 cycles after acceptance
  - next request accepted the cycle after the response handshake
- Write response: rsp_rdata shows the written data (MDR).
- req_ready=0 in every state except IDLE. Requests offered then are ignored and not queued.
- Address is used as-is, with no bounds fault: the full 9-bit range is valid, and addresses 0 and 511 require no special handling.

Optional Feature:
MEM_CTRL_WAITSTATE_EN
- Defined: the WAIT state and counter are compiled in. Read latency becomes 3+WAIT_CYCLES and write latency becomes 2+WAIT_CYCLES. This supports slower or synchronous RAM models.
- Undefined: no WAIT state, no counter logic, latencies exactly as above.

Decomposition:
- Shared package mem_pkg:
  - ADDR_W and DATA_W constants
  - state enum typedef (IDLE, ISSUE, WAIT, CAPTURE, RESP)
  - word_t and addr_t typedefs
- Natural sub-module mem_wait_counter: a loadable 4-bit down-counter with a done flag. It is instantiated only under MEM_CTRL_WAITSTATE_EN.

Test Plan:
- Write 0xDEADBEEF to address 0x005, rsp_ready=1 -> ram_write high for exactly 1 cycle with ram_address=0x005 and ram_datain=0xDEADBEEF. rsp_valid follows 2 cycles after acceptance, with rsp_write=1.
- Read address 0x005 after that write -> ram_read pulses once. rsp_rdata=0xDEADBEEF with rsp_valid 3 cycles after acceptance.
- Response backpressure: hold rsp_ready=0 for 5 cycles during a read of 0x1FF -> rsp_valid and rsp_rdata stay stable, req_ready=0, and a new req_valid is ignored. Release rsp_ready -> IDLE on the next edge.
- Reset mid-transaction: assert reset_n=0 in ISSUE of a write to 0x000 -> all outputs return to reset values on the next edge and no response is produced. Re-request is accepted after reset release.
- Back-to-back: write 0x1FF=0x00000001, then read 0x000 and 0x1FF -> the reads return the correct data, and ram_read and ram_write are never high together.
- With MEM_CTRL_WAITSTATE_EN and WAIT_CYCLES=2 -> read latency is 5 cycles and write latency is 4 cycles. Strobes are still 1 cycle wide.
